leaf_out_packer: RTL

//  Parametrised output stage for a leaf shell: merges NUM_OUT_PORTS user output streams (vld/ack) into one
//  BFT packet stream. Round-robin arbitration, per-port destination table, per-port credit (freespace)

---
 rtl/leaf_out_packer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/leaf_out_packer.sv
// Output stage of a BFT leaf shell: round-robin merge of user output streams into one packet stream.
// Optional per-port sent-packet statistics when LEAF_OUT_PACKER_STATS_EN is defined.
module leaf_out_packer #(
    parameter int PACKET_BITS   = 49,
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_LEAF_BITS = 5,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_ADDR_BITS = 7,
    parameter int NUM_OUT_PORTS = 4,
    parameter int CREDIT_BITS   = 8
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
    input  logic                                    cfg_wr,
    input  logic [NUM_PORT_BITS-1:0]                cfg_port,
    input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0]  cfg_dest,
    input  logic                                    cred_vld,
    input  logic [NUM_PORT_BITS-1:0]                cred_port,
    input  logic [CREDIT_BITS-1:0]                  cred_amt,
    input  logic                                    resend,
    input  logic                                    out_rdy,
    output logic [PACKET_BITS-1:0]                  dout_leaf_interface2bft,
    input  logic [NUM_PORT_BITS-1:0]                stat_sel,
    output logic [31:0]                             stat_cnt
);

    localparam int DEST_BITS = NUM_LEAF_BITS + NUM_PORT_BITS;

    logic [DEST_BITS-1:0]     dest_tbl [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0]   credit   [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] seq_addr [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] rr_ptr;
    logic [PACKET_BITS-1:0]   pkt_p1;
    logic                     vld_p1;
    logic                     out_free;
    logic [NUM_OUT_PORTS-1:0] elig;
    logic                     grant_vld;
    logic [NUM_PORT_BITS-1:0] grant_idx;
    logic [PACKET_BITS-1:0]   grant_pkt;

    // Net credit after a grant and/or a return, clamped at the counter ceiling.
    function automatic logic [CREDIT_BITS-1:0] credit_next(
        input logic [CREDIT_BITS-1:0] cur,
        input logic                   dec,
        input logic [CREDIT_BITS-1:0] add
    );
        logic [CREDIT_BITS:0] sum;
        sum = {1'b0, cur} + {1'b0, add} - {{CREDIT_BITS{1'b0}}, dec};
        if (sum[CREDIT_BITS])
            return '1;
        return sum[CREDIT_BITS-1:0];
    endfunction

    assign vld_p1   = pkt_p1[PACKET_BITS-1];
    assign out_free = !vld_p1 || out_rdy;
    assign dout_leaf_interface2bft = resend ? '0 : pkt_p1;

    // Stage p0: round-robin search from rr_ptr upward, then wrap to the low ports.
    always_comb begin
        elig               = '0;
        grant_vld          = 1'b0;
        grant_idx          = '0;
        grant_pkt          = '0;
        ack_interface2user = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++)
            elig[i] = vld_user2interface[i] && (credit[i] != '0);
        if (!reset && !resend && out_free) begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                if (!grant_vld && elig[i] && (NUM_PORT_BITS'(i) >= rr_ptr)) begin
                    grant_vld = 1'b1;
                    grant_idx = NUM_PORT_BITS'(i);
                end
            end
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                if (!grant_vld && elig[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = NUM_PORT_BITS'(i);
                end
            end
        end
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (grant_vld && (grant_idx == NUM_PORT_BITS'(i))) begin
                ack_interface2user[i] = 1'b1;
                grant_pkt = {1'b1, dest_tbl[i], seq_addr[i],
                             din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
            end
        end
    end

    // Stage p1: output register plus per-port bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
            pkt_p1 <= '0;
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                credit[i]   <= '0;
                seq_addr[i] <= '0;
                dest_tbl[i] <= '0;
            end
        end else begin
            if (grant_vld) begin
                pkt_p1 <= grant_pkt;
                rr_ptr <= (grant_idx == NUM_PORT_BITS'(NUM_OUT_PORTS - 1)) ? '0 : grant_idx + 1'b1;
            end else if (out_rdy && !resend) begin
                pkt_p1 <= '0;
            end
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                credit[i] <= credit_next(credit[i],
                                         grant_vld && (grant_idx == NUM_PORT_BITS'(i)),
                                         (cred_vld && (cred_port == NUM_PORT_BITS'(i))) ? cred_amt : '0);
                if (grant_vld && (grant_idx == NUM_PORT_BITS'(i)))
                    seq_addr[i] <= seq_addr[i] + 1'b1;
                if (cfg_wr && (cfg_port == NUM_PORT_BITS'(i)))
                    dest_tbl[i] <= cfg_dest;
            end
        end
    end

`ifdef LEAF_OUT_PACKER_STATS_EN
    logic [31:0] sent_cnt [NUM_OUT_PORTS];

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_cnt <= '0;
            for (int i = 0; i < NUM_OUT_PORTS; i++)
                sent_cnt[i] <= '0;
        end else begin
            stat_cnt <= '0;
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                if (stat_sel == NUM_PORT_BITS'(i))
                    stat_cnt <= sent_cnt[i];
                if (grant_vld && (grant_idx == NUM_PORT_BITS'(i)))
                    sent_cnt[i] <= sent_cnt[i] + 32'd1;
            end
        end
    end
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_cnt        = '0;
`endif

endmodule
